// File: rtl/input_pkg.sv
// Shared types, constants and helpers for the player input front-end.
package input_pkg;

    localparam logic [1:0]  SRC_PHYS          = 2'd0;
    localparam logic [1:0]  SRC_RAND          = 2'd1;
    localparam logic [1:0]  SRC_NONE          = 2'd2;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Bit offset of player p inside a packed per-player vector.
    function automatic int unsigned btn_base(input int unsigned p, input int unsigned btn_w);
        return p * btn_w;
    endfunction

    // Right-shifting Galois step; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button bit: two-flop synchroniser, optional inversion, persistence filter.
module btn_debounce #(
    parameter int unsigned CYC    = 1000,
    parameter bit          INVERT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int unsigned CNT_W = (CYC > 0) ? $clog2(CYC + 1) : 1;

    logic r_sync1;
    logic r_sync2;

    // Inversion sits ahead of the flops so a reset value of 0 always means released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw ^ INVERT;
            r_sync2 <= r_sync1;
        end
    end

    if (CYC == 0) begin : g_bypass
        assign o_stable = r_sync2;
    end else begin : g_filter
        logic [CNT_W-1:0] r_cnt;
        logic             r_stable;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(CYC - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign o_stable = r_stable;
    end

endmodule

// File: rtl/player_input_hub.sv
// Per-frame button front-end: debounce, source select, LFSR random, frame delay line.
module player_input_hub
    import input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned BTN_W          = 3,
    parameter int unsigned DEBOUNCE_CYC   = 1000,
    parameter int unsigned DELAY_FRAMES   = 0,
    parameter bit          RAW_ACTIVE_LOW = 1'b1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_tick,
    input  logic                         enable,
    input  logic [NUM_PLAYERS*BTN_W-1:0] raw_btn,
    input  logic [2*NUM_PLAYERS-1:0]     src_sel,
    output logic [NUM_PLAYERS*BTN_W-1:0] btn_held,
    output logic [NUM_PLAYERS*BTN_W-1:0] btn_pressed,
    output logic                         frame_valid,
    output logic [15:0]                  lfsr_state
);

    localparam int unsigned TOT_W = NUM_PLAYERS * BTN_W;
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0) ? LFSR_SEED_DEFAULT : LFSR_SEED;

    logic [TOT_W-1:0] w_stable;
    logic [TOT_W-1:0] w_rand;
    logic [TOT_W-1:0] w_sample;
    logic [TOT_W-1:0] w_new;

    logic [TOT_W-1:0] r_held;
    logic [TOT_W-1:0] r_pressed;
    logic             r_valid;
    logic [15:0]      r_lfsr;

    for (genvar gi = 0; gi < TOT_W; gi++) begin : g_btn
        btn_debounce #(
            .CYC    (DEBOUNCE_CYC),
            .INVERT (RAW_ACTIVE_LOW)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_raw    (raw_btn[gi]),
            .o_stable (w_stable[gi])
        );

        // Global bit index gi equals p*BTN_W+b, so the tap pair depends only on gi.
        assign w_rand[gi] = r_lfsr[gi % 16] ^ r_lfsr[(gi + 7) % 16];
    end

    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
        localparam int unsigned BASE = btn_base(gp, BTN_W);
        logic [1:0] w_sel;

        assign w_sel = src_sel[2*gp +: 2];
        assign w_sample[BASE +: BTN_W] =
            !enable             ? '0                       :
            (w_sel == SRC_PHYS) ? w_stable[BASE +: BTN_W] :
            (w_sel == SRC_RAND) ? w_rand[BASE +: BTN_W]   : '0;
    end

    if (DELAY_FRAMES == 0) begin : g_nodly
        assign w_new = w_sample;
    end else begin : g_dly
        localparam int unsigned PTR_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;

        logic [TOT_W-1:0] r_dly [DELAY_FRAMES];
        logic [PTR_W-1:0] r_ptr;

        // Oldest entry is read out and overwritten by the new sample on each tick.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DELAY_FRAMES); i++) begin
                    r_dly[i] <= '0;
                end
                r_ptr <= '0;
            end else if (frame_tick) begin
                r_dly[r_ptr] <= w_sample;
                r_ptr        <= (r_ptr == PTR_W'(DELAY_FRAMES - 1)) ? '0 : r_ptr + PTR_W'(1);
            end
        end

        assign w_new = r_dly[r_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held    <= '0;
            r_pressed <= '0;
            r_valid   <= 1'b0;
            r_lfsr    <= SEED;
        end else begin
            r_valid <= frame_tick;
            if (frame_tick) begin
                r_pressed <= w_new & ~r_held;
                r_held    <= w_new;
                r_lfsr    <= lfsr_next(r_lfsr);
            end
        end
    end

    assign btn_held    = r_held;
    assign btn_pressed = r_pressed;
    assign frame_valid = r_valid;
    assign lfsr_state  = r_lfsr;

endmodule

// File: tb/tb_player_input_hub.sv
// Scoreboard bench for player_input_hub: one instance without and one with a 3-frame delay.
module tb_player_input_hub;

    localparam int unsigned NP = 2;
    localparam int unsigned BW = 3;
    localparam int unsigned TW = NP * BW;

    typedef struct packed {
        logic [TW-1:0] held;
        logic [TW-1:0] pressed;
        logic [15:0]   lfsr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_tick;
    logic          enable;
    logic [TW-1:0] raw_btn;
    logic [2*NP-1:0] src_sel;

    logic [TW-1:0] held0, pressed0, held3, pressed3;
    logic          fv0, fv3;
    logic [15:0]   lfsr0, lfsr3;

    int passes = 0;
    int checks = 0;

    exp_t          q0[$];
    exp_t          q3[$];
    logic [TW-1:0] m_dly[$];
    logic [15:0]   m_lfsr;
    logic [TW-1:0] m_held0, m_held3;

    always #5 clk = ~clk;

    player_input_hub #(
        .NUM_PLAYERS(NP), .BTN_W(BW), .DEBOUNCE_CYC(4), .DELAY_FRAMES(0),
        .RAW_ACTIVE_LOW(1'b1), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .raw_btn(raw_btn), .src_sel(src_sel), .btn_held(held0),
        .btn_pressed(pressed0), .frame_valid(fv0), .lfsr_state(lfsr0)
    );

    player_input_hub #(
        .NUM_PLAYERS(NP), .BTN_W(BW), .DEBOUNCE_CYC(4), .DELAY_FRAMES(3),
        .RAW_ACTIVE_LOW(1'b1), .LFSR_SEED(16'hACE1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .raw_btn(raw_btn), .src_sel(src_sel), .btn_held(held3),
        .btn_pressed(pressed3), .frame_valid(fv3), .lfsr_state(lfsr3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
        else             passes++;
    endtask

    // Right-shift Galois step, taps 0xB400 (0xACE1 -> 0xE270).
    function automatic logic [15:0] galois(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [TW-1:0] model_sample(input logic [TW-1:0] phys);
        logic [TW-1:0] s;
        s = '0;
        if (enable) begin
            for (int p = 0; p < int'(NP); p++) begin
                for (int b = 0; b < int'(BW); b++) begin
                    int k;
                    k = p * int'(BW) + b;
                    case (src_sel[2*p +: 2])
                        2'd0:    s[k] = phys[k];
                        2'd1:    s[k] = m_lfsr[k % 16] ^ m_lfsr[(k + 7) % 16];
                        default: s[k] = 1'b0;
                    endcase
                end
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_held0 = '0;
        m_held3 = '0;
        m_dly.delete();
        repeat (3) m_dly.push_back('0);
    endtask

    // Called in the cycle frame_tick is high, with the debounced physical state expected then.
    task automatic push_frame(input logic [TW-1:0] phys);
        exp_t          e;
        logic [TW-1:0] s, d;
        s = model_sample(phys);
        m_lfsr = galois(m_lfsr);
        e.held = s; e.pressed = s & ~m_held0; e.lfsr = m_lfsr;
        m_held0 = s;
        q0.push_back(e);
        m_dly.push_back(s);
        d = m_dly.pop_front();
        e.held = d; e.pressed = d & ~m_held3;
        m_held3 = d;
        q3.push_back(e);
    endtask

    task automatic tick(input int wait_cyc, input logic [TW-1:0] phys);
        repeat (wait_cyc) @(posedge clk);
        #1 frame_tick = 1'b1;
        push_frame(phys);
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    // Monitor: every frame_valid pulse pops one expectation per instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fv0) begin
                if (q0.size() == 0) chk("dut0_spurious_valid", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("dut0_held", 32'(held0), 32'(e.held));
                    chk("dut0_pressed", 32'(pressed0), 32'(e.pressed));
                    chk("dut0_lfsr", 32'(lfsr0), 32'(e.lfsr));
                end
            end
            if (fv3) begin
                if (q3.size() == 0) chk("dut3_spurious_valid", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q3.pop_front();
                    chk("dut3_held", 32'(held3), 32'(e.held));
                    chk("dut3_pressed", 32'(pressed3), 32'(e.pressed));
                    chk("dut3_lfsr", 32'(lfsr3), 32'(e.lfsr));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_held0"}, 32'(held0), 32'd0);
        chk({tag, "_pressed0"}, 32'(pressed0), 32'd0);
        chk({tag, "_valid0"}, 32'(fv0), 32'd0);
        chk({tag, "_lfsr0"}, 32'(lfsr0), 32'h0000ACE1);
        chk({tag, "_held3"}, 32'(held3), 32'd0);
        chk({tag, "_valid3"}, 32'(fv3), 32'd0);
        chk({tag, "_lfsr3"}, 32'(lfsr3), 32'h0000ACE1);
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        chk({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
        chk({tag, "_q3_left"}, 32'(q3.size()), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        enable     = 1'b1;
        raw_btn    = '1;
        src_sel    = '0;
        model_reset();

        // Reset held while raw pins toggle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 raw_btn = (i % 2 == 0) ? 6'b010101 : 6'b101010;
        end
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1 raw_btn = '1;
        rst_n = 1'b1;

        tick(10, 6'b000000);

        // Three-cycle glitch on bit 0 is filtered out.
        raw_btn[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 raw_btn[0] = 1'b1;
        tick(10, 6'b000000);

        // Sustained press on bit 0: accepted, then held without a new press.
        raw_btn[0] = 1'b0;
        tick(8, 6'b000001);
        tick(3, 6'b000001);

        // Player 1 attack (bit 2) pressed; the delayed instance sees it on the fourth tick.
        raw_btn[2] = 1'b0;
        tick(8, 6'b000101);
        tick(2, 6'b000101);
        tick(2, 6'b000101);
        tick(2, 6'b000101);

        // Player 2 from the random source.
        src_sel = 4'b0100;
        tick(2, 6'b000101);
        tick(2, 6'b000101);

        // All buttons down, then enable off/on and neutral source codes.
        src_sel = 4'b0000;
        raw_btn = '0;
        tick(8, 6'b111111);
        enable = 1'b0;
        tick(2, 6'b111111);
        enable = 1'b1;
        tick(2, 6'b111111);
        src_sel = 4'b1010;
        tick(2, 6'b111111);
        src_sel = 4'b1111;
        tick(2, 6'b111111);
        src_sel = 4'b0000;
        tick(2, 6'b111111);

        // Three back-to-back ticks.
        @(posedge clk);
        #1 frame_tick = 1'b1; push_frame(6'b111111);
        @(posedge clk);
        #1 push_frame(6'b111111);
        @(posedge clk);
        #1 push_frame(6'b111111);
        @(posedge clk);
        #1 frame_tick = 1'b0;
        drain("b2b");

        // Asynchronous reset in mid-cycle.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(10, 6'b111111);
        tick(2, 6'b111111);
        drain("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
